// File: rtl/counter_irq_host.sv
// Initiator for the counter start/ack/irq handshake: runs one command at a time and reports its latency.
// Optional per-state watchdog enabled by defining IRQ_HOST_TIMEOUT_EN.
module counter_irq_host #(
  parameter int unsigned CNT_W = 32
`ifdef IRQ_HOST_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 4096
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             start,
  output logic             ack,
  input  logic             irq_start,
  input  logic             irq_done,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_cycles,
  output logic [CNT_W-1:0] run_count,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_ACK,
    S_REPORT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             start_q, start_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] result_cycles_q, result_cycles_d;
  logic [CNT_W-1:0] run_count_q, run_count_d;
  logic             cmd_accept;

`ifdef IRQ_HOST_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_err_q, timeout_err_d;
  logic            in_wait;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign cmd_accept = cmd_valid && cmd_ready_q;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d         = state_q;
    lat_d           = lat_q;
    result_cycles_d = result_cycles_q;
    run_count_d     = run_count_q;
    result_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          state_d = S_WAIT_START;
          lat_d   = CNT_W'(1);
        end
      end
      S_WAIT_START: begin
        lat_d = sat_inc(lat_q);
        if (irq_start) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        lat_d = sat_inc(lat_q);
        if (irq_done) begin
          state_d         = S_ACK;
          result_cycles_d = lat_q;
        end
      end
      S_ACK: begin
        if (!irq_done) begin
          state_d        = S_REPORT;
          result_valid_d = 1'b1;
          run_count_d    = sat_inc(run_count_q);
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

`ifdef IRQ_HOST_TIMEOUT_EN
    in_wait       = (state_q == S_WAIT_START) || (state_q == S_WAIT_DONE) || (state_q == S_ACK);
    timeout_err_d = timeout_err_q;
    if (cmd_accept) timeout_err_d = 1'b0;
    // A real transition in the final watchdog cycle wins over the timeout
    if (in_wait && (state_d == state_q) && (wd_q == WD_W'(TIMEOUT - 1))) begin
      state_d       = S_IDLE;
      timeout_err_d = 1'b1;
    end
    if (state_d != state_q) wd_d = '0;
    else if (in_wait)       wd_d = wd_q + WD_W'(1);
    else                    wd_d = wd_q;
`endif

    cmd_ready_d = (state_d == S_IDLE);
    start_d     = (state_d == S_WAIT_START);
    ack_d       = (state_d == S_ACK);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cmd_ready_q     <= 1'b0;
      start_q         <= 1'b0;
      ack_q           <= 1'b0;
      busy_q          <= 1'b0;
      result_valid_q  <= 1'b0;
      lat_q           <= '0;
      result_cycles_q <= '0;
      run_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      cmd_ready_q     <= cmd_ready_d;
      start_q         <= start_d;
      ack_q           <= ack_d;
      busy_q          <= busy_d;
      result_valid_q  <= result_valid_d;
      lat_q           <= lat_d;
      result_cycles_q <= result_cycles_d;
      run_count_q     <= run_count_d;
    end
  end

`ifdef IRQ_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign start         = start_q;
  assign ack           = ack_q;
  assign busy          = busy_q;
  assign result_valid  = result_valid_q;
  assign result_cycles = result_cycles_q;
  assign run_count     = run_count_q;

endmodule
